fdivsqrt_uotfc_seq: RTL and testbench
=====================================

FDIVSQRT_UOTFC_SEQ -- requirements
Module: fdivsqrt_uotfc_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8; bit width of U/UM root/quotient registers.
REQ-002 SHALL have parameter RK, default 1; log2 radix, legal values 1 (radix 2) and 2 (radix 4).
REQ-003 SHALL have parameter NDIG, default 8; digits per operation, with NDIG*RK <= WIDTH.
REQ-004 SHALL have ports: clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have ports: reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have ports: start  input  1  begin new operation; loads init values.
REQ-007 SHALL have ports: init_u  input  WIDTH  initial U, sampled on start.
REQ-008 SHALL have ports: init_um  input  WIDTH  initial UM, sampled on start.
REQ-009 SHALL have ports: digit_valid  input  1  digit present this cycle.
REQ-010 SHALL have ports: digit  input  3  signed two's-complement digit.
REQ-011 SHALL have ports: u  output  WIDTH  converted value U.
REQ-012 SHALL have ports: um  output  WIDTH  U minus one ulp of current digit position (UM).
REQ-013 SHALL have ports: busy  output  1  operation in progress, digits accepted.
REQ-014 SHALL have ports: done  output  1  level; NDIG digits converted, u/um final.
REQ-015 SHALL have ports: err  output  1  sticky illegal-digit flag.

Function
REQ-016 SHALL hold WIDTH-bit thermometer register C; K = C & ~(C << 1) (one-hot, lowest set bit of C) marks current digit LSB.
REQ-017 On start: U<=init_u, UM<=init_um, C<=ones in top RK bits only, count<=NDIG, busy<=1, done<=0, err<=0.
REQ-018 A digit SHALL be accepted only when busy=1, digit_valid=1, start=0; otherwise digit_valid ignored.
REQ-019 On accepted digit: C <= C shifted right by RK with ones filled from MSB; count decrements by 1.
REQ-020 Update rule, d>0: U<=U|(d*K), UM<=U|((d-1)*K).
REQ-021 Update rule, d=0: U<=U, UM<=UM|((2^RK-1)*K).
REQ-022 Update rule, d<0: U<=UM|((2^RK-|d|)*K), UM<=UM|((2^RK-1-|d|)*K).
REQ-023 d*K for one-hot K SHALL be formed by OR of shifted K (no multiplier); products never exceed bits K..K<<(RK-1).
REQ-024 Legal digits: RK=1 {-1,0,1}; RK=2 {-2..2}. Accepted illegal digit SHALL set err=1 and leave U, UM, C, count unchanged.
REQ-025 Latency: accepted digit at edge t is visible on u/um immediately after edge t; u, um are direct register outputs.
REQ-026 When the NDIG-th digit is accepted: busy<=0, done<=1 on that same edge.
REQ-027 While idle (busy=0): U, UM, C, done, err held until next start or reset.
REQ-028 start while busy SHALL abort and restart per REQ-017; a same-cycle digit is dropped.
REQ-029 count width SHALL be clog2(NDIG+1); no wrap: digits beyond NDIG are ignored per REQ-018.

Reset
REQ-030 reset=1 at a clock edge SHALL set U=0, UM=0, C=0, count=0, busy=0, done=0, err=0, overriding start and digit_valid.
REQ-031 Reset mid-operation SHALL abandon the operation; no done is produced for it.

Verification
REQ-032 WIDTH=4,RK=1,NDIG=4, start init 0/0, digits 1,0,-1,1 on 4 consecutive cycles -> u=0111, um=0110, done=1 on 4th edge, busy=0.
REQ-033 WIDTH=4,RK=2,NDIG=2, init 0/0, digits 2,-1 -> after 1st u=1000, um=0100; after 2nd u=0111, um=0110, done=1.
REQ-034 RK=1, digit=2 mid-operation -> err=1, u/um/count unchanged; following legal digits still converted; err stays 1 until start.
REQ-035 start asserted with digit_valid on 3rd digit of an operation -> registers reloaded with init values, digit dropped, count=NDIG, done=0.
REQ-036 reset asserted during busy with digit_valid=1 -> all outputs 0 next cycle; digit_valid ignored until next start.
REQ-037 digit_valid gaps (bubbles) between digits and digits after done -> result identical to gap-free run; post-done digits leave u/um unchanged.

Source files
------------

// File: rtl/fdivsqrt_uotfc_seq_if.sv
// Handshake/data bundle for the on-the-fly digit converter: operation control,
// digit stream in, U/UM root/quotient registers and status out.
interface fdivsqrt_uotfc_seq_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] init_u;
   logic [WIDTH-1:0] init_um;
   logic             digit_valid;
   logic [2:0]       digit;
   logic [WIDTH-1:0] u;
   logic [WIDTH-1:0] um;
   logic             busy;
   logic             done;
   logic             err;

   modport master (
      output start, init_u, init_um, digit_valid, digit,
      input  u, um, busy, done, err
   );

   modport slave (
      input  start, init_u, init_um, digit_valid, digit,
      output u, um, busy, done, err
   );
endinterface

// File: rtl/fdivsqrt_uotfc_seq.sv
// Sequential on-the-fly conversion of signed radix-2/4 digits into U and UM = U - ulp,
// using a thermometer register whose lowest set bit marks the current digit position.
module fdivsqrt_uotfc_seq #(
   parameter int WIDTH = 8,
   parameter int RK    = 1,
   parameter int NDIG  = 8
) (
   input logic                 clk,
   input logic                 reset,
   fdivsqrt_uotfc_seq_if.slave bus
);
   localparam int               CW    = $clog2(NDIG + 1);
   localparam logic [WIDTH-1:0] C_TOP = ~({WIDTH{1'b1}} >> RK);
   localparam logic [2:0]       RADIX = 3'(1 << RK);

   logic [WIDTH-1:0] u_q, um_q, c_q, k;
   logic [WIDTH-1:0] u_nxt, um_nxt;
   logic [CW-1:0]    count_q;
   logic             busy_q, done_q, err_q;
   logic [2:0]       mag;
   logic             neg, legal, accept;

   // Small-constant multiple of a one-hot position: OR of shifted copies, no multiplier.
   function automatic logic [WIDTH-1:0] scale_k(input logic [WIDTH-1:0] onehot,
                                                input logic [1:0]       m);
      return ({WIDTH{m[0]}} & onehot) | ({WIDTH{m[1]}} & (onehot << 1));
   endfunction

   always_comb begin
      // NOTE: every output of this block gets a default first so no latch is inferred.
      u_nxt  = u_q;
      um_nxt = um_q;
      neg    = bus.digit[2];
      mag    = neg ? (3'd0 - bus.digit) : bus.digit;
      legal  = (RK == 1) ? (mag <= 3'd1) : (mag <= 3'd2);
      k      = c_q & ~(c_q << 1);
      accept = busy_q & bus.digit_valid & ~bus.start;
      if (neg) begin
         u_nxt  = um_q | scale_k(k, 2'(RADIX - mag));
         um_nxt = um_q | scale_k(k, 2'(RADIX - 3'd1 - mag));
      end else if (mag == 3'd0) begin
         um_nxt = um_q | scale_k(k, 2'(RADIX - 3'd1));
      end else begin
         u_nxt  = u_q | scale_k(k, 2'(mag));
         um_nxt = u_q | scale_k(k, 2'(mag - 3'd1));
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         u_q     <= '0;
         um_q    <= '0;
         c_q     <= '0;
         count_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else if (bus.start) begin
         u_q     <= bus.init_u;
         um_q    <= bus.init_um;
         c_q     <= C_TOP;
         count_q <= CW'(NDIG);
         busy_q  <= 1'b1;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else if (accept) begin
         if (!legal) begin
            err_q <= 1'b1;
         end else begin
            u_q     <= u_nxt;
            um_q    <= um_nxt;
            c_q     <= (c_q >> RK) | C_TOP;
            count_q <= count_q - CW'(1);
            if (count_q == CW'(1)) begin
               busy_q <= 1'b0;
               done_q <= 1'b1;
            end
         end
      end
   end

   assign bus.u    = u_q;
   assign bus.um   = um_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.err  = err_q;
endmodule

// File: tb/tb_fdivsqrt_uotfc_seq.sv
// Three converter configurations checked against an arithmetic model: U is the running
// digit-string value modulo 2^WIDTH and UM is that value minus the weight of the last digit.
module tb_fdivsqrt_uotfc_seq;
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   fdivsqrt_uotfc_seq_if #(.WIDTH(4)) ia ();
   fdivsqrt_uotfc_seq_if #(.WIDTH(4)) ib ();
   fdivsqrt_uotfc_seq_if #(.WIDTH(8)) ic ();

   fdivsqrt_uotfc_seq #(.WIDTH(4), .RK(1), .NDIG(4)) dut_a (.clk(clk), .reset(reset), .bus(ia.slave));
   fdivsqrt_uotfc_seq #(.WIDTH(4), .RK(2), .NDIG(2)) dut_b (.clk(clk), .reset(reset), .bus(ib.slave));
   fdivsqrt_uotfc_seq #(.WIDTH(8), .RK(2), .NDIG(4)) dut_c (.clk(clk), .reset(reset), .bus(ic.slave));

   localparam int WOF  [3] = '{4, 4, 8};
   localparam int RKOF [3] = '{1, 2, 2};
   localparam int NDOF [3] = '{4, 2, 4};

   int     total = 0;
   int     bad = 0;
   longint q [3];
   longint mu [3];
   longint mum [3];
   int     nacc [3];
   logic   mb [3];
   logic   md [3];
   logic   me [3];

   function automatic longint wrap(input longint x, input int w);
      longint m;
      m = longint'(1) << w;
      return ((x % m) + m) % m;
   endfunction

   function automatic logic [18:0] exp_of(input int idx);
      return {8'(mu[idx]), 8'(mum[idx]), mb[idx], md[idx], me[idx]};
   endfunction

   task automatic drive(input int idx, input logic st, input logic [7:0] iu, input logic [7:0] ium,
                        input logic dv, input logic [2:0] dg);
      ia.start = 1'b0; ia.digit_valid = 1'b0; ia.init_u = '0; ia.init_um = '0; ia.digit = '0;
      ib.start = 1'b0; ib.digit_valid = 1'b0; ib.init_u = '0; ib.init_um = '0; ib.digit = '0;
      ic.start = 1'b0; ic.digit_valid = 1'b0; ic.init_u = '0; ic.init_um = '0; ic.digit = '0;
      case (idx)
         0: begin ia.start = st; ia.init_u = iu[3:0]; ia.init_um = ium[3:0]; ia.digit_valid = dv; ia.digit = dg; end
         1: begin ib.start = st; ib.init_u = iu[3:0]; ib.init_um = ium[3:0]; ib.digit_valid = dv; ib.digit = dg; end
         default: begin ic.start = st; ic.init_u = iu; ic.init_um = ium; ic.digit_valid = dv; ic.digit = dg; end
      endcase
   endtask

   task automatic sample(input int idx, output logic [18:0] got);
      case (idx)
         0: got = {8'(ia.u), 8'(ia.um), ia.busy, ia.done, ia.err};
         1: got = {8'(ib.u), 8'(ib.um), ib.busy, ib.done, ib.err};
         default: got = {ic.u, ic.um, ic.busy, ic.done, ic.err};
      endcase
   endtask

   task automatic model(input int idx, input logic rst, input logic st, input logic [7:0] iu,
                        input logic [7:0] ium, input logic dv, input logic [2:0] dg);
      int     d, lim;
      longint w;
      if (rst) begin
         for (int k = 0; k < 3; k++) begin
            q[k] = 0; mu[k] = 0; mum[k] = 0; nacc[k] = 0; mb[k] = 0; md[k] = 0; me[k] = 0;
         end
      end else if (st) begin
         q[idx] = longint'(iu); mu[idx] = longint'(iu); mum[idx] = longint'(ium);
         nacc[idx] = 0; mb[idx] = 1; md[idx] = 0; me[idx] = 0;
      end else if (dv && mb[idx]) begin
         d   = int'($signed(dg));
         lim = (RKOF[idx] == 1) ? 1 : 2;
         if (d > lim || d < -lim) begin
            me[idx] = 1;
         end else begin
            nacc[idx]++;
            w        = longint'(1) << (WOF[idx] - nacc[idx] * RKOF[idx]);
            q[idx]   = q[idx] + longint'(d) * w;
            mu[idx]  = wrap(q[idx], WOF[idx]);
            mum[idx] = wrap(q[idx] - w, WOF[idx]);
            if (nacc[idx] == NDOF[idx]) begin
               mb[idx] = 0;
               md[idx] = 1;
            end
         end
      end
   endtask

   task automatic step(input int idx, input logic rst, input logic st, input logic [7:0] iu,
                       input logic [7:0] ium, input logic dv, input logic [2:0] dg,
                       output logic [18:0] got, output logic [18:0] exp);
      reset = rst;
      drive(idx, st, iu, ium, dv, dg);
      @(posedge clk);
      #1;
      model(idx, rst, st, iu, ium, dv, dg);
      sample(idx, got);
      exp = exp_of(idx);
   endtask

   task automatic go(input int idx, output logic [18:0] got, output logic [18:0] exp);
      step(idx, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 3'b000, got, exp);
   endtask

   task automatic dig(input int idx, input logic dv, input logic [2:0] dg,
                      output logic [18:0] got, output logic [18:0] exp);
      step(idx, 1'b0, 1'b0, 8'h00, 8'h00, dv, dg, got, exp);
   endtask

   function automatic logic [2:0] rand_legal(input int idx);
      int lim;
      lim = (RKOF[idx] == 1) ? 1 : 2;
      return 3'(int'($urandom_range(0, 2 * lim)) - lim);
   endfunction

   task automatic test_reset;
      logic [18:0] got, exp;
      step(0, 1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1, 3'b001, got, exp);
      step(0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 3'b000, got, exp);
      for (int k = 0; k < 3; k++) begin
         sample(k, got);
         total++;
         if (got !== 19'd0) begin bad++; $display("FAIL reset idx=%0d got=%h exp=0", k, got); end
      end
   endtask

   task automatic test_radix2_vector;
      logic [18:0] got, exp;
      logic [2:0]  digs [4] = '{3'b001, 3'b000, 3'b111, 3'b001};
      go(0, got, exp);
      total++;
      if (got !== exp) begin bad++; $display("FAIL r2_vec start got=%h exp=%h", got, exp); end
      for (int i = 0; i < 4; i++) begin
         dig(0, 1'b1, digs[i], got, exp);
         total++;
         if (got !== exp) begin bad++; $display("FAIL r2_vec digit%0d got=%h exp=%h", i, got, exp); end
      end
      total++;
      if ({ia.u, ia.um, ia.busy, ia.done} !== {4'b0111, 4'b0110, 1'b0, 1'b1}) begin
         bad++; $display("FAIL r2_vec final got u=%b um=%b busy=%b done=%b exp 0111/0110/0/1", ia.u, ia.um, ia.busy, ia.done);
      end
   endtask

   task automatic test_radix4_vector;
      logic [18:0] got, exp;
      go(1, got, exp);
      dig(1, 1'b1, 3'b010, got, exp);
      total++;
      if ({ib.u, ib.um, ib.done} !== {4'b1000, 4'b0100, 1'b0}) begin
         bad++; $display("FAIL r4_vec first got u=%b um=%b done=%b exp 1000/0100/0", ib.u, ib.um, ib.done);
      end
      dig(1, 1'b1, 3'b111, got, exp);
      total++;
      if ({ib.u, ib.um, ib.busy, ib.done} !== {4'b0111, 4'b0110, 1'b0, 1'b1}) begin
         bad++; $display("FAIL r4_vec second got u=%b um=%b busy=%b done=%b exp 0111/0110/0/1", ib.u, ib.um, ib.busy, ib.done);
      end
      total++;
      if (got !== exp) begin bad++; $display("FAIL r4_vec model got=%h exp=%h", got, exp); end
   endtask

   task automatic test_illegal;
      logic [18:0] got, exp;
      logic [2:0]  digs [7] = '{3'b001, 3'b010, 3'b110, 3'b000, 3'b111, 3'b001, 3'b011};
      go(0, got, exp);
      for (int i = 0; i < 7; i++) begin
         dig(0, 1'b1, digs[i], got, exp);
         total++;
         if (got !== exp) begin bad++; $display("FAIL illegal cyc%0d got=%h exp=%h", i, got, exp); end
         if (i == 1) begin
            total++;
            if ({ia.u, ia.um, ia.err, ia.busy} !== {4'b1000, 4'b0000, 1'b1, 1'b1}) begin
               bad++; $display("FAIL illegal hold got u=%b um=%b err=%b busy=%b exp 1000/0000/1/1", ia.u, ia.um, ia.err, ia.busy);
            end
         end
      end
      go(0, got, exp);
      total++;
      if (got !== exp) begin bad++; $display("FAIL illegal clear got=%h exp=%h", got, exp); end
   endtask

   task automatic test_bubbles;
      logic [18:0] got, exp;
      logic        dvs  [10] = '{1, 0, 1, 0, 0, 1, 0, 1, 1, 1};
      logic [2:0]  digs [10] = '{3'b001, 3'b111, 3'b000, 3'b001, 3'b111, 3'b111, 3'b000, 3'b001, 3'b111, 3'b001};
      go(0, got, exp);
      for (int i = 0; i < 10; i++) begin
         dig(0, dvs[i], digs[i], got, exp);
         total++;
         if (got !== exp) begin bad++; $display("FAIL bubbles cyc%0d got=%h exp=%h", i, got, exp); end
      end
      total++;
      if ({ia.u, ia.um, ia.done} !== {4'b0111, 4'b0110, 1'b1}) begin
         bad++; $display("FAIL bubbles final got u=%b um=%b done=%b exp 0111/0110/1", ia.u, ia.um, ia.done);
      end
   endtask

   task automatic test_abort;
      logic [18:0] got, exp;
      go(2, got, exp);
      dig(2, 1'b1, 3'b001, got, exp);
      dig(2, 1'b1, 3'b110, got, exp);
      step(2, 1'b0, 1'b1, 8'hA5, 8'h5A, 1'b1, 3'b001, got, exp);
      total++;
      if ({ic.u, ic.um, ic.busy, ic.done} !== {8'hA5, 8'h5A, 1'b1, 1'b0}) begin
         bad++; $display("FAIL abort reload got u=%h um=%h busy=%b done=%b exp a5/5a/1/0", ic.u, ic.um, ic.busy, ic.done);
      end
      dig(2, 1'b1, 3'b010, got, exp);
      step(2, 1'b0, 1'b1, 8'h00, 8'h00, 1'b1, 3'b010, got, exp);
      for (int i = 0; i < 4; i++) begin
         dig(2, 1'b1, rand_legal(2), got, exp);
         total++;
         if (got !== exp) begin bad++; $display("FAIL abort count digit%0d got=%h exp=%h", i, got, exp); end
      end
   endtask

   task automatic test_reset_mid;
      logic [18:0] got, exp;
      go(2, got, exp);
      dig(2, 1'b1, 3'b001, got, exp);
      dig(2, 1'b1, 3'b111, got, exp);
      step(2, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 3'b001, got, exp);
      total++;
      if (got !== 19'd0) begin bad++; $display("FAIL reset_mid got=%h exp=0", got); end
      for (int i = 0; i < 5; i++) begin
         dig(2, 1'b1, 3'b001, got, exp);
         total++;
         if (got !== exp) begin bad++; $display("FAIL reset_mid idle%0d got=%h exp=%h", i, got, exp); end
      end
   endtask

   task automatic test_back_to_back;
      logic [18:0] got, exp;
      for (int op = 0; op < 4; op++) begin
         go(1, got, exp);
         for (int i = 0; i < 2; i++) begin
            dig(1, 1'b1, rand_legal(1), got, exp);
            total++;
            if (got !== exp) begin bad++; $display("FAIL b2b op%0d digit%0d got=%h exp=%h", op, i, got, exp); end
         end
      end
   endtask

   task automatic test_random;
      logic [18:0] got, exp;
      logic [2:0]  dg;
      logic        dv;
      for (int idx = 0; idx < 3; idx++) begin
         for (int op = 0; op < 30; op++) begin
            go(idx, got, exp);
            for (int c = 0; c < 3 * NDOF[idx] + 2; c++) begin
               dv = ($urandom_range(0, 3) != 0);
               dg = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : rand_legal(idx);
               if ($urandom_range(0, 39) == 0)
                  step(idx, 1'b0, 1'b1, 8'h00, 8'h00, dv, dg, got, exp);
               else
                  dig(idx, dv, dg, got, exp);
               total++;
               if (got !== exp) begin
                  bad++; $display("FAIL random idx=%0d op=%0d cyc=%0d got=%h exp=%h", idx, op, c, got, exp);
               end
            end
         end
      end
   endtask

   initial begin
      drive(0, 1'b0, 8'h00, 8'h00, 1'b0, 3'b000);
      test_reset();
      test_radix2_vector();
      test_radix4_vector();
      test_illegal();
      test_bubbles();
      test_abort();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
